// File: rtl/reg_arbiter.sv
// reg_arbiter -- two-requester arbiter in front of a two-entry register file.
//
// Each requester raises req with wr/addr/wr_data held until its one-cycle
// gnt pulse. A winning request is captured in IDLE or RESP, presented to the
// register file in ACCESS, and for reads the registered rf_data is returned
// to the winner in RESP. Throughput is one operation every two cycles.
//
// Configuration macro: REG_ARBITER_RR_EN
//   defined   : contended samples go to the requester not served last
//   undefined : fixed priority, requester 0 wins a contended sample
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   req0/1, wr0/1, addr0/1, wr_data0/1 : requester command inputs
//   gnt0/1                : one-cycle grant pulse (request captured)
//   rd_valid0/1, rd_data0/1 : read response (data is 0 when valid is low)
//   rf_addr, rf_write, rf_write_data : register-file command
//   rf_data               : registered register-file read data
module reg_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             wr0,
  input  logic             wr1,
  input  logic             addr0,
  input  logic             addr1,
  input  logic [WIDTH-1:0] wr_data0,
  input  logic [WIDTH-1:0] wr_data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rd_valid0,
  output logic             rd_valid1,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1,
  output logic             rf_addr,
  output logic             rf_write,
  output logic [WIDTH-1:0] rf_write_data,
  input  logic [WIDTH-1:0] rf_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic capture;       // a request is being accepted at this edge
  logic win;           // arbitration result for this sample (0 or 1)
  logic winner;        // requester owning the in-flight operation
  logic write_pending; // captured operation is a write; high only in ACCESS
  logic gnt0_next;
  logic gnt1_next;
  logic rd_valid0_next;
  logic rd_valid1_next;

`ifdef REG_ARBITER_RR_EN
  logic last;          // requester served most recently
`endif

  assign capture = ((state == IDLE) || (state == RESP)) && (req0 || req1);

  // Arbitration: a lone request wins outright; contention uses the policy.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
`ifdef REG_ARBITER_RR_EN
      win = ~last;
`else
      win = 1'b0;
`endif
    end else if (req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, RESP: begin
        if (req0 || req1) begin
          state_next = ACCESS;
        end else begin
          state_next = IDLE;
        end
      end
      ACCESS:  state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: next values of the registered grant and read-valid flags.
  always_comb begin
    gnt0_next      = 1'b0;
    gnt1_next      = 1'b0;
    rd_valid0_next = 1'b0;
    rd_valid1_next = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (capture) begin
          gnt0_next = ~win;
          gnt1_next = win;
        end else begin
          gnt0_next = 1'b0;
          gnt1_next = 1'b0;
        end
      end
      ACCESS: begin
        // write_pending mirrors the captured op type during ACCESS.
        if (!write_pending) begin
          rd_valid0_next = ~winner;
          rd_valid1_next = winner;
        end else begin
          rd_valid0_next = 1'b0;
          rd_valid1_next = 1'b0;
        end
      end
      default: begin
        gnt0_next      = 1'b0;
        gnt1_next      = 1'b0;
        rd_valid0_next = 1'b0;
        rd_valid1_next = 1'b0;
      end
    endcase
  end

  // Capture registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      rd_valid0     <= 1'b0;
      rd_valid1     <= 1'b0;
      rf_addr       <= 1'b0;
      rf_write_data <= {WIDTH{1'b0}};
      write_pending <= 1'b0;
      winner        <= 1'b0;
    end else begin
      gnt0      <= gnt0_next;
      gnt1      <= gnt1_next;
      rd_valid0 <= rd_valid0_next;
      rd_valid1 <= rd_valid1_next;
      if (capture) begin
        rf_addr       <= win ? addr1 : addr0;
        rf_write_data <= win ? wr_data1 : wr_data0;
        write_pending <= win ? wr1 : wr0;
        winner        <= win;
      end else begin
        // Address and data hold until the next capture; the write strobe
        // lasts only for the ACCESS cycle.
        write_pending <= 1'b0;
      end
    end
  end

`ifdef REG_ARBITER_RR_EN
  // Round-robin pointer, updated on every grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      last <= 1'b1;
    end else if (capture) begin
      last <= win;
    end else begin
      last <= last;
    end
  end
`endif

  // Reset blocks the write immediately so an abandoned ACCESS commits nothing.
  assign rf_write = write_pending & ~reset;

  assign rd_data0 = rd_valid0 ? rf_data : {WIDTH{1'b0}};
  assign rd_data1 = rd_valid1 ? rf_data : {WIDTH{1'b0}};

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed self-checking bench for reg_arbiter with a two-entry register
// file model and a scoreboard of expected read responses.
module tb_reg_arbiter;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         preload;
  logic         req0, req1, wr0, wr1, addr0, addr1;
  logic [W-1:0] wr_data0, wr_data1;
  logic         gnt0, gnt1, rd_valid0, rd_valid1;
  logic [W-1:0] rd_data0, rd_data1;
  logic         rf_addr, rf_write;
  logic [W-1:0] rf_write_data;
  logic [W-1:0] rf_data;
  logic [W-1:0] rf_mem [2];
  logic [W-1:0] exp_mem [2];

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic         who;
    logic [W-1:0] data;
  } exp_t;
  exp_t sb [$];

  reg_arbiter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .rf_addr(rf_addr), .rf_write(rf_write), .rf_write_data(rf_write_data),
    .rf_data(rf_data)
  );

  always #5 clock = ~clock;

  // Register file: write commits at the edge, read data is registered.
  always @(posedge clock) begin
    if (preload) begin
      rf_mem[0] <= 8'h33;
      rf_mem[1] <= 8'h44;
    end else if (rf_write) begin
      rf_mem[rf_addr] <= rf_write_data;
    end
    rf_data <= rf_mem[rf_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, 32'({gnt0, gnt1, rd_valid0, rd_valid1, rf_write, rf_addr,
                    rd_data0, rd_data1, rf_write_data}), 32'd0);
  endtask

  // One uncontended operation, started at a negedge while the arbiter can sample.
  task automatic op(input logic who, input logic wr, input logic addr,
                    input logic [W-1:0] data, input string tag);
    exp_t e;
    if (who == 1'b0) begin
      req0 = 1'b1; wr0 = wr; addr0 = addr; wr_data0 = data;
    end else begin
      req1 = 1'b1; wr1 = wr; addr1 = addr; wr_data1 = data;
    end
    if (wr) exp_mem[addr] = data;
    else    sb.push_back('{who, exp_mem[addr]});
    @(negedge clock);
    check({tag, " gnt"}, 32'({gnt1, gnt0}), (who == 1'b0) ? 32'd1 : 32'd2);
    check({tag, " rf_write"}, 32'(rf_write), 32'(wr));
    check({tag, " rf_addr"}, 32'(rf_addr), 32'(addr));
    if (wr) check({tag, " rf_write_data"}, 32'(rf_write_data), 32'(data));
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clock);
    check({tag, " resp gnt"}, 32'({gnt1, gnt0}), 32'd0);
    if (wr) begin
      check({tag, " rd_valid"}, 32'({rd_valid1, rd_valid0}), 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " rd_valid"}, 32'({rd_valid1, rd_valid0}), (e.who == 1'b0) ? 32'd1 : 32'd2);
      check({tag, " rd_data"}, 32'(e.who ? rd_data1 : rd_data0), 32'(e.data));
      check({tag, " rd_data other"}, 32'(e.who ? rd_data0 : rd_data1), 32'd0);
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; preload = 1'b1;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = 1'b0; addr1 = 1'b0; wr_data0 = 8'h00; wr_data1 = 8'h00;
    exp_mem[0] = 8'h33; exp_mem[1] = 8'h44;
    repeat (2) @(negedge clock);
    preload = 1'b0;
    check_idle("reset state");

    // A request seen on a reset edge must be ignored.
    req0 = 1'b1; wr0 = 1'b1; addr0 = 1'b1; wr_data0 = 8'hA5;
    @(negedge clock);
    check_idle("req during reset");
    req0 = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check_idle("idle after reset");

    op(1'b0, 1'b1, 1'b1, 8'h5A, "w0 a1 5a");
    op(1'b1, 1'b0, 1'b1, 8'h00, "r1 a1");

    // Back-to-back from requester 0: one operation every two cycles.
    op(1'b0, 1'b1, 1'b0, 8'h01, "b2b w a0");
    op(1'b0, 1'b1, 1'b1, 8'h02, "b2b w a1");
    op(1'b0, 1'b0, 1'b0, 8'h00, "b2b r a0");
    op(1'b0, 1'b0, 1'b1, 8'h00, "b2b r a1");

    // Both requesters held continuously, starting from a fresh pointer.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 1'b0;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef REG_ARBITER_RR_EN
      sb.push_back('{1'(k % 2), exp_mem[k % 2]});
`else
      sb.push_back('{1'b0, exp_mem[0]});
`endif
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c % 2 == 1) begin
        check($sformatf("contend gnt %0d", c), 32'({gnt1, gnt0}),
              (sb[0].who == 1'b0) ? 32'd1 : 32'd2);
      end else begin
        e = sb.pop_front();
        check($sformatf("contend gnt idle %0d", c), 32'({gnt1, gnt0}), 32'd0);
        check($sformatf("contend rd_valid %0d", c), 32'({rd_valid1, rd_valid0}),
              (e.who == 1'b0) ? 32'd1 : 32'd2);
        check($sformatf("contend rd_data %0d", c), 32'(e.who ? rd_data1 : rd_data0),
              32'(e.data));
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clock);
    check("contend drained", 32'({gnt1, gnt0, rd_valid1, rd_valid0}), 32'd0);

    // Reset during the ACCESS cycle of a write abandons it.
    req0 = 1'b1; wr0 = 1'b1; addr0 = 1'b0; wr_data0 = 8'hFF;
    @(negedge clock);
    check("abort gnt", 32'({gnt1, gnt0}), 32'd1);
    check("abort rf_write before reset", 32'(rf_write), 32'd1);
    reset = 1'b1;
    #1;
    check("abort rf_write gated", 32'(rf_write), 32'd0);
    req0 = 1'b0;
    @(negedge clock);
    check_idle("abort outputs");
    reset = 1'b0;
    @(negedge clock);
    check_idle("abort idle");
    op(1'b0, 1'b0, 1'b0, 8'h00, "read after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each requester port and of the register-file port.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous reset, active-high, sampled on the rising edge of Clock.
REQ-004 Req0, Req1  input  1 each  access request from requester 0 / 1; held high until the matching Gnt.
REQ-005 Wr0, Wr1  input  1 each  operation select, 1 = write, 0 = read; held with Req.
REQ-006 Addr0, Addr1  input  1 each  register address (0 or 1); held with Req.
REQ-007 WrData0, WrData1  input  WIDTH each  write data; held with Req.
REQ-008 Gnt0, Gnt1  output  1 each  one-cycle grant pulse; the request has been captured.
REQ-009 RdValid0, RdValid1  output  1 each  read data valid for requester 0 / 1.
REQ-010 RdData0, RdData1  output  WIDTH each  read data; 0 whenever the matching RdValid is low.
REQ-011 RfAddr  output  1  address to the register file.
REQ-012 RfWrite  output  1  write enable to the register file.
REQ-013 RfWriteData  output  WIDTH  write data to the register file.
REQ-014 RfData  input  WIDTH  registered read data from the register file; valid one edge after address presentation.

Function
REQ-015 The FSM SHALL have the states IDLE, ACCESS and RESP.
REQ-016 IDLE or RESP with no Req high: next state IDLE.
REQ-017 IDLE or RESP with any Req high: capture the winner's Wr, Addr and WrData, set the winner register, pulse Gnt for the winner in the following cycle, next state ACCESS.
REQ-018 ACCESS: next state RESP unconditionally; Req inputs ignored.
REQ-019 Arbitration SHALL use a single request only when one Req is high, and follow REQ-033/034 when both are high.
REQ-020 RfAddr and RfWriteData SHALL present the captured values from the ACCESS cycle onward and hold them until the next capture.
REQ-021 RfWrite SHALL be 1 only in ACCESS with a captured write, and is forced to 0 combinationally while Reset is high.
REQ-022 RESP with a captured read: RdValid of the winner = 1 and its RdData = RfData for that cycle; all other RdValid/RdData = 0.
REQ-023 A captured write produces no RdValid.
REQ-024 Latency: Req sampled at edge E, Gnt high in cycle E+1 (ACCESS), RdValid high in cycle E+2 (RESP); sustained throughput is one operation every 2 cycles.
REQ-025 Gnt0 and Gnt1 SHALL never be high together, and RdValid0 and RdValid1 SHALL never be high together.
REQ-026 A requester that keeps Req high after its Gnt is treated as a new request at the next RESP or IDLE sample.
REQ-027 A read captured directly after a write to the same address returns the written value; the write commits at the ACCESS edge before the read's ACCESS cycle.

Reset
REQ-028 Reset high at an edge SHALL force state to IDLE.
REQ-029 Reset SHALL clear all of the following: Gnt*, RdValid*, RdData*, RfWrite, RfAddr and RfWriteData to 0, and the round-robin pointer to "last served = 1".
REQ-030 Reset during ACCESS or RESP SHALL abandon the in-flight operation with no write committed and no RdValid.
REQ-031 Requests present on the edge where Reset is high SHALL be ignored.
REQ-032 Register-file contents are not reset by this block.

Configuration
REQ-033 With REG_ARBITER_RR_EN defined: on simultaneous requests, grant the requester not served last; the pointer updates on every grant, single or contended.
REQ-034 Without REG_ARBITER_RR_EN: fixed priority, Req0 always wins a contended sample; no pointer state is built.

Verification
REQ-035 After reset, Req0=1 Wr0=1 Addr0=1 WrData0=8'h5A -> Gnt0 in cycle 1, RfWrite=1 RfAddr=1 RfWriteData=8'h5A in cycle 1, no RdValid.
REQ-036 Then Req1=1 Wr1=0 Addr1=1 -> Gnt1 one cycle after sample, RdValid1=1 RdData1=8'h5A one cycle later, RdData0=0.
REQ-037 Req0 and Req1 held high continuously with RR_EN -> grants alternate 0,1,0,1 every 2 cycles; without RR_EN -> Gnt0 every 2 cycles and Gnt1 never.
REQ-038 Reset asserted in the ACCESS cycle of a write of 8'hFF to address 0 -> RfWrite=0; a subsequent read of address 0 returns the prior value; state IDLE; all outputs 0.
REQ-039 Back-to-back sequence write addr0=8'h01, write addr1=8'h02, read addr0, read addr1 from Req0 -> RdData0 = 8'h01 then 8'h02, with one operation every 2 cycles.
